// File: rtl/stream_mux_pkg.sv
// Shared constants for the two-input stream selector: source encoding, default sizing
// and the burst-counter width helper.
package stream_mux_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 2;

    // The counter must be able to hold MAX_BURST itself, since it saturates there.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_arb2_burst.sv
// Two-way round-robin arbiter with bounded bursts.
// Owns last_src and burst_cnt and produces the grant for the current cycle.
module rr_arb2_burst
    import stream_mux_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_a_valid,
    input  logic i_b_valid,
    input  logic i_out_free,
    input  logic i_xfer,
    output logic o_grant_vld,
    output logic o_grant_src
);

    localparam int              CW    = cnt_width(MAX_BURST);
    localparam logic [CW-1:0]   MAX_C = CW'(MAX_BURST);
    localparam logic [CW-1:0]   ONE_C = CW'(1);

    logic          r_last_src;
    logic [CW-1:0] r_burst_cnt;
    logic          w_grant_vld;
    logic          w_grant_src;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_src = SRC_A;
        if (i_out_free) begin
            if (i_a_valid && i_b_valid) begin
                w_grant_vld = 1'b1;
                // Stay with the current source until its burst allowance is used up.
                w_grant_src = (r_burst_cnt < MAX_C) ? r_last_src : ~r_last_src;
            end else if (i_a_valid) begin
                w_grant_vld = 1'b1;
                w_grant_src = SRC_A;
            end else if (i_b_valid) begin
                w_grant_vld = 1'b1;
                w_grant_src = SRC_B;
            end
        end
    end

    assign o_grant_vld = w_grant_vld;
    assign o_grant_src = w_grant_src;

    // Reset state makes the first tie after reset go to A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_src  <= SRC_B;
            r_burst_cnt <= MAX_C;
        end else if (i_xfer) begin
            if (w_grant_src == r_last_src) begin
                if (r_burst_cnt < MAX_C) begin
                    r_burst_cnt <= r_burst_cnt + ONE_C;
                end
            end else begin
                r_last_src  <= w_grant_src;
                r_burst_cnt <= ONE_C;
            end
        end
    end

endmodule

// File: rtl/stream_mux2_arb.sv
// Two-input stream selector feeding the 2:1 data mux: arbitrates A/B, drives s0
// and holds the selected beat in an output register drained by valid/ready.
module stream_mux2_arb
    import stream_mux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             s0,
    input  logic             y_ready
);

    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    logic             r_s0;

    logic             w_out_free;
    logic             w_grant_vld;
    logic             w_grant_src;
    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    assign w_out_free = !r_y_valid || y_ready;

    rr_arb2_burst #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_a_valid   (a_valid),
        .i_b_valid   (b_valid),
        .i_out_free  (w_out_free),
        .i_xfer      (w_xfer),
        .o_grant_vld (w_grant_vld),
        .o_grant_src (w_grant_src)
    );

    // Readies are held low while reset is asserted so no handshake can complete.
    assign w_a_ready = rst_n && w_out_free && w_grant_vld && (w_grant_src == SRC_A);
    assign w_b_ready = rst_n && w_out_free && w_grant_vld && (w_grant_src == SRC_B);

    assign w_xfer     = (a_valid && w_a_ready) || (b_valid && w_b_ready);
    assign w_sel_data = (w_grant_src == SRC_B) ? b_data : a_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_s0      <= SRC_A;
        end else if (w_xfer) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_sel_data;
            r_s0      <= w_grant_src;
        end else if (y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;
    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign s0      = r_s0;

endmodule

// File: tb/tb_stream_mux2_arb.sv
// Scoreboard bench for stream_mux2_arb: directed streams push hand-computed beats,
// a negedge monitor pops and compares every output handshake.
module tb_stream_mux2_arb;

    logic       clk;
    logic       rst_n;
    logic       a_valid, b_valid, y_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, y_valid, s0;
    logic [7:0] y_data;

    logic       a2_valid, b2_valid, y2_ready;
    logic [7:0] a2_data, b2_data;
    logic       a2_ready, b2_ready, y2_valid, s0_2;
    logic [7:0] y2_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    logic [8:0] exp_q[$];
    logic       a_en, b_en, yr;
    logic       s_ar, s_br;

    stream_mux2_arb #(.WIDTH(8), .MAX_BURST(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .s0(s0), .y_ready(y_ready)
    );

    stream_mux2_arb #(.WIDTH(8), .MAX_BURST(1)) dut_alt (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a2_valid), .a_data(a2_data), .a_ready(a2_ready),
        .b_valid(b2_valid), .b_data(b2_data), .b_ready(b2_ready),
        .y_valid(y2_valid), .y_data(y2_data), .s0(s0_2), .y_ready(y2_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {23'd0, s0, y_data}, 32'h1ff);
            end else begin
                check("beat", {23'd0, s0, y_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // One clock: drive at posedge+1, sample readies at negedge, retire accepted beats.
    task automatic step(input int n);
        logic acc_a, acc_b;
        for (int i = 0; i < n; i++) begin
            a_valid = a_en && (a_q.size() > 0);
            a_data  = a_valid ? a_q[0] : 8'h00;
            b_valid = b_en && (b_q.size() > 0);
            b_data  = b_valid ? b_q[0] : 8'h00;
            y_ready = yr;
            @(negedge clk);
            s_ar  = a_ready;
            s_br  = b_ready;
            check("one_ready", {31'd0, s_ar & s_br}, 32'd0);
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (acc_a) void'(a_q.pop_front());
            if (acc_b) void'(b_q.pop_front());
        end
    endtask

    task automatic do_reset();
        check("drained", exp_q.size(), 0);
        exp_q.delete();
        rst_n = 1'b0;
        a_q.delete();
        b_q.delete();
        a_en = 1'b0;
        b_en = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic push_ab_streams();
        for (int n = 0; n < 4; n++) begin
            a_q.push_back(8'hA0 + 8'(n));
            b_q.push_back(8'hB0 + 8'(n));
        end
        exp_q.push_back(9'h0A0); exp_q.push_back(9'h0A1);
        exp_q.push_back(9'h1B0); exp_q.push_back(9'h1B1);
        exp_q.push_back(9'h0A2); exp_q.push_back(9'h0A3);
        exp_q.push_back(9'h1B2); exp_q.push_back(9'h1B3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_alt[4];
        exp_alt = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0;
        a_en = 1'b0; b_en = 1'b0; yr = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00; y_ready = 1'b1;
        a2_valid = 1'b1; b2_valid = 1'b1; a2_data = 8'h5A; b2_data = 8'hA5; y2_ready = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset held with both sources valid
        a_q.push_back(8'h33);
        b_q.push_back(8'h44);
        a_en = 1'b1; b_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check("rst_y_valid", {31'd0, y_valid}, 32'd0);
            check("rst_s0", {31'd0, s0}, 32'd0);
            check("rst_y_data", {24'd0, y_data}, 32'd0);
            check("rst_a_ready", {31'd0, s_ar}, 32'd0);
            check("rst_b_ready", {31'd0, s_br}, 32'd0);
        end
        a_q.delete(); b_q.delete();
        a_en = 1'b0; b_en = 1'b0;
        rst_n = 1'b1;

        // 2: A only, one-cycle latency
        a_q.push_back(8'h11); a_q.push_back(8'h12); a_q.push_back(8'h13);
        exp_q.push_back(9'h011); exp_q.push_back(9'h012); exp_q.push_back(9'h013);
        a_en = 1'b1; yr = 1'b1;
        step(1);
        check("a_only_b_ready", {31'd0, s_br}, 32'd0);
        check("lat_y_valid", {31'd0, y_valid}, 32'd1);
        check("lat_y_data", {24'd0, y_data}, 32'h11);
        check("lat_s0", {31'd0, s0}, 32'd0);
        step(4);

        // 3: both valid, bursts of two
        do_reset();
        push_ab_streams();
        a_en = 1'b1; b_en = 1'b1; yr = 1'b1;
        step(10);

        // 4: backpressure mid-stream
        do_reset();
        push_ab_streams();
        a_en = 1'b1; b_en = 1'b1; yr = 1'b1;
        step(3);
        yr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check("stall_a_ready", {31'd0, s_ar}, 32'd0);
            check("stall_b_ready", {31'd0, s_br}, 32'd0);
            check("stall_y_valid", {31'd0, y_valid}, 32'd1);
            check("stall_y_data", {24'd0, y_data}, 32'hB0);
            check("stall_s0", {31'd0, s0}, 32'd1);
        end
        yr = 1'b1;
        step(7);

        // 5: A streams alone, then B wins the first tie
        do_reset();
        for (int n = 0; n < 5; n++) begin
            a_q.push_back(8'h50 + 8'(n));
            exp_q.push_back({1'b0, 8'h50 + 8'(n)});
        end
        a_en = 1'b1; b_en = 1'b1; yr = 1'b1;
        step(5);
        a_q.push_back(8'h55); a_q.push_back(8'h56);
        b_q.push_back(8'h60); b_q.push_back(8'h61);
        exp_q.push_back(9'h160); exp_q.push_back(9'h161);
        exp_q.push_back(9'h055); exp_q.push_back(9'h056);
        step(1);
        check("starve_b_ready", {31'd0, s_br}, 32'd1);
        check("starve_a_ready", {31'd0, s_ar}, 32'd0);
        step(4);

        // 6: asynchronous reset mid-burst, then power-up behaviour
        check("drained", exp_q.size(), 0);
        a_q.push_back(8'h70); a_q.push_back(8'h71);
        exp_q.push_back(9'h070);
        step(2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_y_valid", {31'd0, y_valid}, 32'd0);
        a_q.delete(); b_q.delete();
        a_q.push_back(8'h80); a_q.push_back(8'h81);
        b_q.push_back(8'h90); b_q.push_back(8'h91);
        @(posedge clk);
        #1;
        step(1);
        check("rst_mid_a_ready", {31'd0, s_ar}, 32'd0);
        check("rst_mid_b_ready", {31'd0, s_br}, 32'd0);
        check("rst_mid_y_valid", {31'd0, y_valid}, 32'd0);
        check("drained", exp_q.size(), 0);
        exp_q.push_back(9'h080); exp_q.push_back(9'h081);
        exp_q.push_back(9'h190); exp_q.push_back(9'h191);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1);
            if (c == 0) begin
                check("post_rst_first_a", {31'd0, s_ar}, 32'd1);
                check("post_rst_first_b", {31'd0, s_br}, 32'd0);
            end
            check("alt_y_valid", {31'd0, y2_valid}, 32'd1);
            check("alt_s0", {31'd0, s0_2}, {31'd0, exp_alt[c]});
        end
        step(2);

        check("final_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux2_arb.md
Name: stream_mux2_arb

Overview:
- Two-input stream selector that sits directly upstream of the 2:1 data mux.
- Arbitrates between source A and source B, each with a valid/ready handshake, using round-robin with bounded bursts.
- Drives the select line s0 and holds the chosen beat in an output register. Downstream consumes the register through a valid/ready handshake.
- Convention: s0=0 means source A, s0=1 means source B.

Parameters:
- WIDTH, 8: data width of a_data, b_data and y_data.
- MAX_BURST, 2: maximum consecutive beats granted to one source while the other source is also requesting. Legal range is 1..15; 1 gives pure alternation.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_valid  in  1  source A has a beat.
- a_data  in  WIDTH  source A payload.
- a_ready  out  1  A beat accepted this cycle when a_valid && a_ready.
- b_valid  in  1  source B has a beat.
- b_data  in  WIDTH  source B payload.
- b_ready  out  1  B beat accepted this cycle when b_valid && b_ready.
- y_valid  out  1  output register holds a beat.
- y_data  out  WIDTH  output payload.
- s0  out  1  source of the beat in y_data (0=A, 1=B).
- y_ready  in  1  downstream accepts the beat when y_valid && y_ready.

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values while rst_n=0, applied asynchronously:
  - y_valid=0, y_data=0, s0=0.
  - last_src=B, burst_cnt=MAX_BURST, so the first tie after reset goes to A.
  - a_ready=0 and b_ready=0 are forced while rst_n is low.
- out_free = !y_valid || y_ready, i.e. the register is empty or is being drained this cycle.
- Grant is combinational and is only evaluated when out_free=1:
  - Only A valid: grant A. Only B valid: grant B. Neither valid: no grant.
  - Both valid and burst_cnt < MAX_BURST: grant last_src.
  - Both valid and burst_cnt >= MAX_BURST: grant the other source.
- Ready outputs:
  - a_ready = out_free && grant==A.
  - b_ready = out_free && grant==B.
  - A ready never depends on the same source's valid being low; ready may depend on valid (combinational path valid->ready is allowed). At most one ready is high per cycle.
- On an input transfer:
  - Next edge: y_data takes the granted data, s0 takes the granted source, y_valid=1.
  - Latency is exactly 1 cycle, and full throughput is 1 beat/cycle.
- If out_free=1 and no grant, then on y_ready y_valid goes to 0 and y_data/s0 hold their last value.
- Burst counter update, on transfer only:
  - Granted source == last_src: burst_cnt = min(burst_cnt+1, MAX_BURST).
  - Otherwise: last_src = granted source and burst_cnt = 1.
  - No transfer: last_src and burst_cnt hold.
  - The counter saturates and never wraps.
- Backpressure: while y_valid && !y_ready, y_data and s0 are stable, both readies are 0, and arbitration state is frozen.
- Single-source streaming saturates burst_cnt. When the other source becomes valid it wins the next tie immediately, so starvation is bounded by MAX_BURST beats.
- Simultaneous drain and fill (y_valid && y_ready and an input transfer in the same cycle) replaces the beat with no bubble.
- Reset mid-operation:
  - The held beat is discarded and y_valid drops asynchronously.
  - Any in-flight handshake is void.
  - After release, behaviour is identical to power-up.
- Inputs are not registered. Sources must hold valid and data stable until ready (standard valid/ready rules); the block does not check this.

Decomposition:
- Shared package stream_mux_pkg:
  - Source encoding constants SRC_A=1'b0 and SRC_B=1'b1.
  - Default WIDTH and MAX_BURST.
  - Counter width function clog2(MAX_BURST+1).
- One sub-module, rr_arb2_burst. It owns last_src and burst_cnt, takes the valids plus out_free and a transfer strobe, and produces the grant.
- The top level holds the output register, the ready logic and the data select.

Test Plan (WIDTH=8, MAX_BURST=2 unless stated):
1. Hold rst_n=0 for 3 cycles with a_valid=b_valid=1 -> y_valid=0, s0=0, y_data=0x00, a_ready=b_ready=0 throughout.
2. A only: a_data 0x11,0x12,0x13 on consecutive cycles, y_ready=1 -> y_data 0x11,0x12,0x13 one cycle later each, s0=0, b_ready=0.
3. Both valid continuously (A sends 0xA0+n, B sends 0xB0+n), y_ready=1 -> s0 sequence 0,0,1,1,0,0; y_data A0,A1,B0,B1,A2,A3.
4. Both valid, y_ready=0 for 3 cycles mid-stream -> y_data and s0 stable, a_ready=b_ready=0. After release the sequence resumes with no lost or duplicated beat and the burst count is unchanged.
5. A streaming 5 beats alone, then B becomes valid -> the next grant is B (s0=1) on the first cycle both are valid.
6. rst_n pulsed low for 1 cycle mid-burst -> y_valid drops without waiting for clk. After release with both valid, the first grant is A. With MAX_BURST=1, both valid gives s0 alternating 0,1,0,1.
